// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared constants and helpers for the register file slice.
//            Default data width / depth, RISC-V ABI register indices and a
//            helper for slicing flattened multi-port buses.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int unsigned c_XLEN_DEFAULT  = 32;
  localparam int unsigned c_NREGS_DEFAULT = 32;

  // RISC-V ABI register indices
  localparam int unsigned c_ABI_ZERO = 0;
  localparam int unsigned c_ABI_RA   = 1;
  localparam int unsigned c_ABI_SP   = 2;
  localparam int unsigned c_ABI_GP   = 3;
  localparam int unsigned c_ABI_TP   = 4;
  localparam int unsigned c_ABI_T0   = 5;
  localparam int unsigned c_ABI_T1   = 6;
  localparam int unsigned c_ABI_T2   = 7;
  localparam int unsigned c_ABI_S0   = 8;
  localparam int unsigned c_ABI_S1   = 9;
  localparam int unsigned c_ABI_A0   = 10;
  localparam int unsigned c_ABI_A1   = 11;

  // Low bit index of element idx in a flattened bus of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Per-register busy bits for RAW/WAW hazard detection. An accepted
//            issue marks its destination busy, a writeback clears it; when
//            both hit the same register in one cycle the new owner wins.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            rd_addr  [NRD*AW]      - read port addresses (flattened)
//            rd_busy  [NRD]         - hazard flag per read port
//            wr_en, wr_addr         - writeback strobe / destination
//            iss_en, iss_addr       - issue request / destination
//            iss_ready              - issue accepted this cycle
//            busy_vec [NREGS]       - full scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic             w_iss_zero;
  logic             w_wb_hits_iss;
  logic             w_iss_accept;

  assign w_iss_zero    = (ZERO_REG != 0) && (iss_addr == '0);
  assign w_wb_hits_iss = wr_en && (wr_addr == iss_addr);
  // A busy destination may still be re-issued when its pending write
  // retires in this very cycle.
  assign iss_ready     = w_iss_zero || !r_busy[iss_addr] || w_wb_hits_iss;
  assign w_iss_accept  = iss_en && iss_ready && !w_iss_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        // Set has priority over clear: the newly issued owner wins.
        if (w_iss_accept && (iss_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (wr_en && (wr_addr == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = r_busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
    logic [AW-1:0] w_a;
    logic          w_zero;
    logic          w_fwd;
    assign w_a        = rd_addr[slice_lo(k, AW) +: AW];
    assign w_zero     = (ZERO_REG != 0) && (w_a == '0);
    // Data being forwarded this cycle is no longer a hazard for the reader.
    assign w_fwd      = (BYPASS != 0) && wr_en && (wr_addr == w_a);
    assign rd_busy[k] = r_busy[w_a] && !w_zero && !w_fwd;
  end

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Parametrised general-purpose register file with NRD
//            combinational read ports, one write port, optional same-cycle
//            write-to-read bypass and a busy-bit scoreboard for issue.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            rd_addr  [NRD*AW]      - read addresses (flattened)
//            rd_data  [NRD*XLEN]    - read data, combinational
//            rd_busy  [NRD]         - pending-write flag per read port
//            wr_en, wr_addr, wr_data- writeback
//            iss_en, iss_addr       - issue request
//            iss_ready              - issue accepted this cycle
//            busy_vec [NREGS]       - full scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = c_XLEN_DEFAULT,
  parameter int NREGS    = c_NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_ok;

  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_d;
    assign w_a = rd_addr[slice_lo(k, AW) +: AW];

    always_comb begin
      w_d = r_regs[w_a];
      if ((ZERO_REG != 0) && (w_a == '0)) begin
        w_d = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == w_a)) begin
        w_d = wr_data;
      end
    end

    assign rd_data[slice_lo(k, XLEN) +: XLEN] = w_d;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec)
  );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Self-checking bench for reg_file_sb. Two instances (bypass on
//            and off, NRD=4, XLEN=64, NREGS=16) share one stimulus stream;
//            expected outputs are queued by the driver and popped by an
//            independent monitor each cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 4;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data_b,   rd_data_n;
  logic [NRD-1:0]      rd_busy_b,   rd_busy_n;
  logic                iss_ready_b, iss_ready_n;
  logic [NREGS-1:0]    busy_vec_b,  busy_vec_n;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ready(iss_ready_b), .busy_vec(busy_vec_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ready(iss_ready_n), .busy_vec(busy_vec_n)
  );

  typedef struct packed {
    logic [NRD*XLEN-1:0] data_b;
    logic [NRD*XLEN-1:0] data_n;
    logic [NRD-1:0]      rb_b;
    logic [NRD-1:0]      rb_n;
    logic                ready;
    logic [NREGS-1:0]    bv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural state
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_valid = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_read(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr_en && (int'(wr_addr) == a)) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit ref_rbusy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && (int'(wr_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit ref_ready();
    if (iss_addr == 0) return 1'b1;
    if (wr_en && (wr_addr == iss_addr)) return 1'b1;
    return !m_busy[iss_addr];
  endfunction

  function automatic logic [NRD*AW-1:0] rd4(input int a0, a1, a2, a3);
    logic [NRD*AW-1:0] v;
    v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    return v;
  endfunction

  // One clock of stimulus: drive, queue the expected combinational outputs
  // for this cycle, then advance the model to the state after the edge.
  task automatic cycle(input bit r, input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit ie, input int ia, input logic [NRD*AW-1:0] ra);
    exp_t e;
    bit   rdy;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia); rd_addr = ra;
    #1;
    rdy = ref_ready();
    if (m_valid) begin
      for (int k = 0; k < NRD; k++) begin
        int a;
        a = int'(ra[k*AW +: AW]);
        e.data_b[k*XLEN +: XLEN] = ref_read(a, 1'b1);
        e.data_n[k*XLEN +: XLEN] = ref_read(a, 1'b0);
        e.rb_b[k] = ref_rbusy(a, 1'b1);
        e.rb_n[k] = ref_rbusy(a, 1'b0);
      end
      e.ready = rdy;
      for (int i = 0; i < NREGS; i++) e.bv[i] = m_busy[i];
      q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (ie && rdy && ia != 0) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic idle(input logic [NRD*AW-1:0] ra);
    cycle(0, 0, 0, '0, 0, 0, ra);
  endtask

  // Monitor: every cycle with a queued expectation, compare both instances
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < NRD; k++) begin
          chk($sformatf("rd_data_byp[%0d]", k), rd_data_b[k*XLEN +: XLEN], e.data_b[k*XLEN +: XLEN]);
          chk($sformatf("rd_data_nobyp[%0d]", k), rd_data_n[k*XLEN +: XLEN], e.data_n[k*XLEN +: XLEN]);
        end
        chk("rd_busy_byp", XLEN'(rd_busy_b), XLEN'(e.rb_b));
        chk("rd_busy_nobyp", XLEN'(rd_busy_n), XLEN'(e.rb_n));
        chk("iss_ready_byp", XLEN'(iss_ready_b), XLEN'(e.ready));
        chk("iss_ready_nobyp", XLEN'(iss_ready_n), XLEN'(e.ready));
        chk("busy_vec_byp", XLEN'(busy_vec_b), XLEN'(e.bv));
        chk("busy_vec_nobyp", XLEN'(busy_vec_n), XLEN'(e.bv));
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

    // Reset, then preload and reset again
    cycle(1, 0, 0, '0, 0, 0, rd4(0, 1, 2, 3));
    idle(rd4(1, 2, 3, 4));
    for (int i = 1; i < NREGS; i++) cycle(0, 1, i, {32'hC0DE0000, 32'(i)}, 1, i, rd4(i, i - 1, 0, 15));
    idle(rd4(1, 5, 9, 15));
    cycle(1, 0, 0, '0, 0, 0, rd4(1, 5, 9, 15));
    idle(rd4(1, 5, 9, 15));
    cycle(1, 1, 5, 64'h55, 1, 6, rd4(5, 6, 0, 1));
    idle(rd4(5, 6, 7, 8));

    // Write then read in the same cycle, then the next cycle
    cycle(0, 1, 3, 64'hDEADBEEF, 0, 0, rd4(3, 3, 2, 0));
    idle(rd4(3, 1, 2, 0));

    // Zero register
    cycle(0, 1, 0, 64'h12345678, 1, 0, rd4(0, 0, 0, 0));
    cycle(0, 0, 0, '0, 1, 0, rd4(0, 3, 0, 3));
    idle(rd4(0, 0, 0, 0));

    // Scoreboard stall on x7
    cycle(0, 0, 0, '0, 1, 7, rd4(7, 7, 3, 0));
    cycle(0, 0, 0, '0, 1, 7, rd4(7, 1, 7, 0));
    cycle(0, 1, 7, 64'hA5A5A5A5, 0, 0, rd4(7, 7, 7, 7));
    idle(rd4(7, 7, 7, 7));

    // Simultaneous issue and writeback, same and different addresses
    cycle(0, 0, 0, '0, 1, 9, rd4(9, 0, 0, 0));
    cycle(0, 1, 9, 64'h11, 1, 9, rd4(9, 9, 0, 0));
    idle(rd4(9, 9, 0, 0));
    cycle(0, 0, 0, '0, 1, 4, rd4(4, 6, 0, 0));
    cycle(0, 1, 4, 64'h44, 1, 6, rd4(4, 6, 4, 6));
    idle(rd4(4, 6, 9, 7));

    // Multi-port: distinct then identical addresses
    for (int i = 10; i < 14; i++) cycle(0, 1, i, {$urandom, $urandom}, 0, 0, rd4(0, 0, 0, 0));
    idle(rd4(10, 11, 12, 13));
    idle(rd4(12, 12, 12, 12));

    // Randomised regression; addresses biased low to provoke hazards
    for (int n = 0; n < 10000; n++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      cycle(r, 1'($urandom), int'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom), int'($urandom_range(0, 7)),
            rd4(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15))));
    end

    idle(rd4(0, 1, 2, 3));
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
